// File: rtl/dht11_pkg.sv
// Shared DHT11 timing defaults and helpers, used by both the sensor emulator and the host reader.
package dht11_pkg;

    localparam int DHT_CLK_FREQ       = 12_000_000;
    localparam int DHT_T_START_MIN_US = 10_000;
    localparam int DHT_T_WAIT_US      = 30;
    localparam int DHT_T_RESP_LOW_US  = 80;
    localparam int DHT_T_RESP_HIGH_US = 85;
    localparam int DHT_T_BIT_LOW_US   = 54;
    localparam int DHT_T_ZERO_US      = 26;
    localparam int DHT_T_ONE_US       = 70;
    localparam int NUM_FRAME_BITS     = 40;

    typedef logic [7:0] dht_byte_t;

    function automatic int us_to_cycles(input int clk_freq, input int us);
        return (clk_freq / 1_000_000) * us;
    endfunction

    function automatic dht_byte_t dht_checksum(input logic [31:0] d);
        return d[31:24] + d[23:16] + d[15:8] + d[7:0];
    endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer for the single-wire data line; resets to the idle-high level.
module dht_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 sensor emulator: accepts a host start pulse and answers with response and a 40-bit frame.
//
// state        | meaning
// S_IDLE       | waiting for a host falling edge
// S_START_LOW  | timing the host start low
// S_WAIT_REL   | gap after host release
// S_RESP_LOW   | driving the response low
// S_RESP_HIGH  | releasing for the response high
// S_BIT_LOW    | driving the low before each bit
// S_BIT_HIGH   | releasing for a 0 or 1 bit width
// S_END_LOW    | driving the end-of-frame low
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int CLK_FREQ       = DHT_CLK_FREQ,
    parameter int T_START_MIN_US = DHT_T_START_MIN_US,
    parameter int T_WAIT_US      = DHT_T_WAIT_US,
    parameter int T_RESP_LOW_US  = DHT_T_RESP_LOW_US,
    parameter int T_RESP_HIGH_US = DHT_T_RESP_HIGH_US,
    parameter int T_BIT_LOW_US   = DHT_T_BIT_LOW_US,
    parameter int T_ZERO_US      = DHT_T_ZERO_US,
    parameter int T_ONE_US       = DHT_T_ONE_US
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_in,
    input  logic [31:0] data_in,
    output logic        line_oe,
    output logic        busy,
    output logic        frame_done,
    output logic        err_start
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START_LOW = 3'd1;
    localparam logic [2:0] S_WAIT_REL  = 3'd2;
    localparam logic [2:0] S_RESP_LOW  = 3'd3;
    localparam logic [2:0] S_RESP_HIGH = 3'd4;
    localparam logic [2:0] S_BIT_LOW   = 3'd5;
    localparam logic [2:0] S_BIT_HIGH  = 3'd6;
    localparam logic [2:0] S_END_LOW   = 3'd7;

    localparam logic [17:0] START_MIN = 18'(us_to_cycles(CLK_FREQ, T_START_MIN_US));
    localparam logic [17:0] WAIT_CYC  = 18'(us_to_cycles(CLK_FREQ, T_WAIT_US));
    localparam logic [17:0] RLOW_CYC  = 18'(us_to_cycles(CLK_FREQ, T_RESP_LOW_US));
    localparam logic [17:0] RHIGH_CYC = 18'(us_to_cycles(CLK_FREQ, T_RESP_HIGH_US));
    localparam logic [17:0] BLOW_CYC  = 18'(us_to_cycles(CLK_FREQ, T_BIT_LOW_US));
    localparam logic [17:0] ZERO_CYC  = 18'(us_to_cycles(CLK_FREQ, T_ZERO_US));
    localparam logic [17:0] ONE_CYC   = 18'(us_to_cycles(CLK_FREQ, T_ONE_US));
    localparam logic [5:0]  LAST_BIT  = 6'(NUM_FRAME_BITS - 1);

    logic        ls;
    logic        ls_q;
    logic        fall;
    logic [2:0]  state;
    logic [17:0] cnt;
    logic [17:0] phase_len;
    logic        phase_end;
    logic [39:0] sh;
    logic [5:0]  bit_idx;

    dht_line_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (line_in),
        .q       (ls)
    );

    assign fall = ls_q & ~ls;

    // Each timed phase ends on its last cycle so line_oe holds exactly phase_len cycles.
    always_comb begin
        phase_len = '0;
        case (state)
            S_WAIT_REL:  phase_len = WAIT_CYC;
            S_RESP_LOW:  phase_len = RLOW_CYC;
            S_RESP_HIGH: phase_len = RHIGH_CYC;
            S_BIT_LOW:   phase_len = BLOW_CYC;
            S_BIT_HIGH:  phase_len = sh[39] ? ONE_CYC : ZERO_CYC;
            S_END_LOW:   phase_len = BLOW_CYC;
            default:     phase_len = '0;
        endcase
    end

    assign phase_end = (cnt == phase_len - 18'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sh         <= '0;
            bit_idx    <= '0;
            ls_q       <= 1'b1;
            line_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_start  <= 1'b0;
        end else begin
            ls_q       <= ls;
            frame_done <= 1'b0;
            err_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        cnt   <= '0;
                        state <= S_START_LOW;
                    end
                end
                S_START_LOW: begin
                    if (ls) begin
                        cnt <= '0;
                        if (cnt >= START_MIN) begin
                            busy  <= 1'b1;
                            state <= S_WAIT_REL;
                        end else begin
                            err_start <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else if (cnt < START_MIN) begin
                        cnt <= cnt + 18'd1;
                    end
                end
                S_WAIT_REL: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        sh      <= {data_in, dht_checksum(data_in)};
                        line_oe <= 1'b1;
                        state   <= S_RESP_LOW;
                    end else cnt <= cnt + 18'd1;
                end
                S_RESP_LOW: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        line_oe <= 1'b0;
                        state   <= S_RESP_HIGH;
                    end else cnt <= cnt + 18'd1;
                end
                S_RESP_HIGH: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        line_oe <= 1'b1;
                        bit_idx <= '0;
                        state   <= S_BIT_LOW;
                    end else cnt <= cnt + 18'd1;
                end
                S_BIT_LOW: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        line_oe <= 1'b0;
                        state   <= S_BIT_HIGH;
                    end else cnt <= cnt + 18'd1;
                end
                S_BIT_HIGH: begin
                    if (phase_end) begin
                        cnt     <= '0;
                        sh      <= {sh[38:0], 1'b0};
                        line_oe <= 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= S_END_LOW;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                            state   <= S_BIT_LOW;
                        end
                    end else cnt <= cnt + 18'd1;
                end
                S_END_LOW: begin
                    if (phase_end) begin
                        cnt        <= '0;
                        line_oe    <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end else cnt <= cnt + 18'd1;
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
